core_dmem_arbiter: RTL and testbench
====================================

CORE_DMEM_ARBITER -- requirements
Module: core_dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 64, meaning dmem address width.
REQ-002 SHALL have parameter MEM_DATA_W, default 64, meaning dmem data width; strobe width is MEM_DATA_W/8.
REQ-003 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-004 SHALL have port g_clk, input, 1, the global clock; all state updates on the rising edge.
REQ-005 SHALL have port g_resetn, input, 1, global reset; synchronous, active-low.
REQ-006 SHALL have ports m0_req and m1_req, input, 1, requester N transaction request; held until mN_gnt.
REQ-007 SHALL have ports m0_addr and m1_addr, input, MEM_ADDR_W, requester N address.
REQ-008 SHALL have ports m0_wen and m1_wen, input, 1, requester N write enable.
REQ-009 SHALL have ports m0_strb and m1_strb, input, MEM_DATA_W/8, requester N write strobe.
REQ-010 SHALL have ports m0_wdata and m1_wdata, input, MEM_DATA_W, requester N write data.
REQ-011 SHALL have ports m0_gnt and m1_gnt, output, 1, requester N response valid.
REQ-012 SHALL have ports m0_err and m1_err, output, 1, requester N response error; valid only with mN_gnt.
REQ-013 SHALL have ports m0_rdata and m1_rdata, output, MEM_DATA_W, requester N read data; valid only with mN_gnt.
REQ-014 SHALL have ports dmem_req, dmem_addr, dmem_wen, dmem_strb and dmem_wdata, outputs, widths 1, MEM_ADDR_W, 1, MEM_DATA_W/8 and MEM_DATA_W, the shared memory request.
REQ-015 SHALL have ports dmem_gnt, dmem_err and dmem_rdata, inputs, widths 1, 1 and MEM_DATA_W, the shared memory response.

Function
REQ-016 SHALL hold an owner state machine with states IDLE, BUSY0 and BUSY1, plus a 1-bit last-served register.
REQ-017 SHALL, in IDLE, select a winner combinationally in the same cycle: a sole requester wins; if both request, ROUND_ROBIN=1 picks the requester not equal to last, and ROUND_ROBIN=0 picks m0.
REQ-018 SHALL drive the dmem_* request fields from the selected requester with zero added latency; dmem_req = selected mN_req.
REQ-019 SHALL drive dmem_addr, dmem_wen, dmem_strb and dmem_wdata to all-zero when dmem_req=0.
REQ-020 SHALL, in IDLE with a winner and dmem_gnt=1 in the same cycle, complete the transfer, set last=winner and remain in IDLE.
REQ-021 SHALL, in IDLE with a winner and dmem_gnt=0, move to BUSYw on the next edge.
REQ-022 SHALL, in BUSYx, select requester x only; the other requester is ignored, and there is no preemption.
REQ-023 SHALL, in BUSYx with dmem_gnt=1, return to IDLE and set last=x; the next arbitration happens in the following cycle.
REQ-024 SHALL, in BUSYx with mx_req=0 (requester abort), deassert dmem_req in that cycle and return to IDLE without updating last.
REQ-025 SHALL set mN_gnt = dmem_gnt AND (selected requester == N); the unselected requester's mN_gnt SHALL be 0.
REQ-026 SHALL set mN_err = dmem_err AND mN_gnt; an error response completes the transaction like a normal gnt.
REQ-027 SHALL broadcast dmem_rdata to both m0_rdata and m1_rdata.
REQ-028 SHALL ignore dmem_gnt while dmem_req=0; the state SHALL NOT change.
REQ-029 SHALL guarantee that, with ROUND_ROBIN=1 and both requesters continuously requesting, grants alternate strictly and neither requester waits more than one transaction.

Reset
REQ-030 SHALL, while g_resetn=0 is sampled, set state to IDLE and last to 1, so that m0 wins the first tie.
REQ-031 SHALL, while g_resetn=0, force dmem_req=0, m0_gnt=0 and m1_gnt=0, regardless of the inputs.
REQ-032 SHALL, on reset asserted mid-transaction, drop ownership; the requester reissues its request after reset.

Verification
REQ-033 SHALL be verified with only m1 requesting (m1_addr=0x80, dmem_gnt the same cycle): dmem_addr=0x80, m1_gnt=1, m0_gnt=0, state stays IDLE.
REQ-034 SHALL be verified with m0 and m1 requesting simultaneously after reset under ROUND_ROBIN=1, each gnt 2 cycles late: service order m0, m1, m0, m1 with no idle cycle between IDLE re-arbitrations.
REQ-035 SHALL be verified with m0 in BUSY0, m1 raised, and gnt after 3 cycles: dmem fields track m0 for all 3 cycles, and m1 is served next.
REQ-036 SHALL be verified with dmem_err=1 together with gnt for an m1 load (rdata=0xDEAD): m1_err=1, m1_gnt=1, m1_rdata=0xDEAD, m0_err=0.
REQ-037 SHALL be verified with g_resetn pulsed low while in BUSY1: dmem_req=0 during reset; after reset, with both requesting, m0 wins.
REQ-038 SHALL be verified with ROUND_ROBIN=0 and both requesting for 4 transactions: m0 is served all 4 while m1_gnt stays 0.

Source files
------------

// File: rtl/core_dmem_arbiter.sv
// Two-requester arbiter in front of a single data-memory port.
// Winner selection and request muxing are combinational; ownership is held until gnt or abort.
module core_dmem_arbiter #(
  parameter int unsigned MEM_ADDR_W  = 64,
  parameter int unsigned MEM_DATA_W  = 64,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic                    g_clk,
  input  logic                    g_resetn,

  input  logic                    m0_req,
  input  logic [MEM_ADDR_W-1:0]   m0_addr,
  input  logic                    m0_wen,
  input  logic [MEM_DATA_W/8-1:0] m0_strb,
  input  logic [MEM_DATA_W-1:0]   m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_err,
  output logic [MEM_DATA_W-1:0]   m0_rdata,

  input  logic                    m1_req,
  input  logic [MEM_ADDR_W-1:0]   m1_addr,
  input  logic                    m1_wen,
  input  logic [MEM_DATA_W/8-1:0] m1_strb,
  input  logic [MEM_DATA_W-1:0]   m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_err,
  output logic [MEM_DATA_W-1:0]   m1_rdata,

  output logic                    dmem_req,
  output logic [MEM_ADDR_W-1:0]   dmem_addr,
  output logic                    dmem_wen,
  output logic [MEM_DATA_W/8-1:0] dmem_strb,
  output logic [MEM_DATA_W-1:0]   dmem_wdata,
  input  logic                    dmem_gnt,
  input  logic                    dmem_err,
  input  logic [MEM_DATA_W-1:0]   dmem_rdata
);

  localparam int unsigned STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state_r;
  logic   last_r;
  logic   sel_valid_s;
  logic   sel_s;

  // Pick the requester that owns the memory port this cycle
  always_comb begin
    sel_valid_s = 1'b0;
    sel_s       = 1'b0;
    if (!g_resetn) begin
      sel_valid_s = 1'b0;
      sel_s       = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_req && m1_req) begin
            sel_valid_s = 1'b1;
            sel_s       = (ROUND_ROBIN != 32'd0) ? ~last_r : 1'b0;
          end else if (m0_req) begin
            sel_valid_s = 1'b1;
            sel_s       = 1'b0;
          end else if (m1_req) begin
            sel_valid_s = 1'b1;
            sel_s       = 1'b1;
          end else begin
            sel_valid_s = 1'b0;
            sel_s       = 1'b0;
          end
        end
        BUSY0: begin
          sel_valid_s = m0_req;
          sel_s       = 1'b0;
        end
        BUSY1: begin
          sel_valid_s = m1_req;
          sel_s       = 1'b1;
        end
        default: begin
          sel_valid_s = 1'b0;
          sel_s       = 1'b0;
        end
      endcase
    end
  end

  // Route the selected request to memory; quiet bus when nobody is selected
  always_comb begin
    dmem_req   = 1'b0;
    dmem_addr  = {MEM_ADDR_W{1'b0}};
    dmem_wen   = 1'b0;
    dmem_strb  = {STRB_W{1'b0}};
    dmem_wdata = {MEM_DATA_W{1'b0}};
    if (sel_valid_s) begin
      dmem_req = 1'b1;
      if (sel_s) begin
        dmem_addr  = m1_addr;
        dmem_wen   = m1_wen;
        dmem_strb  = m1_strb;
        dmem_wdata = m1_wdata;
      end else begin
        dmem_addr  = m0_addr;
        dmem_wen   = m0_wen;
        dmem_strb  = m0_strb;
        dmem_wdata = m0_wdata;
      end
    end else begin
      dmem_req = 1'b0;
    end
  end

  assign m0_gnt   = dmem_gnt & sel_valid_s & ~sel_s;
  assign m1_gnt   = dmem_gnt & sel_valid_s &  sel_s;
  assign m0_err   = dmem_err & m0_gnt;
  assign m1_err   = dmem_err & m1_gnt;
  assign m0_rdata = dmem_rdata;
  assign m1_rdata = dmem_rdata;

  // Ownership FSM and last-served tracking; an abort leaves last untouched
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (sel_valid_s && dmem_gnt) begin
            last_r <= sel_s;
          end else if (sel_valid_s) begin
            state_r <= sel_s ? BUSY1 : BUSY0;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY0: begin
          if (!sel_valid_s) begin
            state_r <= IDLE;
          end else if (dmem_gnt) begin
            state_r <= IDLE;
            last_r  <= 1'b0;
          end else begin
            state_r <= BUSY0;
          end
        end
        BUSY1: begin
          if (!sel_valid_s) begin
            state_r <= IDLE;
          end else if (dmem_gnt) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
          end else begin
            state_r <= BUSY1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_dmem_arbiter.sv
// Directed bench for core_dmem_arbiter: round-robin and fixed-priority instances share the stimulus.
module tb_core_dmem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        m0_req, m1_req, m0_wen, m1_wen, dmem_gnt, dmem_err;
  logic [63:0] m0_addr, m1_addr, m0_wdata, m1_wdata, dmem_rdata;
  logic [7:0]  m0_strb, m1_strb;

  logic        rr_m0_gnt, rr_m0_err, rr_m1_gnt, rr_m1_err, rr_dmem_req, rr_dmem_wen;
  logic [63:0] rr_m0_rdata, rr_m1_rdata, rr_dmem_addr, rr_dmem_wdata;
  logic [7:0]  rr_dmem_strb;
  logic        fp_m0_gnt, fp_m0_err, fp_m1_gnt, fp_m1_err, fp_dmem_req, fp_dmem_wen;
  logic [63:0] fp_m0_rdata, fp_m1_rdata, fp_dmem_addr, fp_dmem_wdata;
  logic [7:0]  fp_dmem_strb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 g_clk = ~g_clk;

  core_dmem_arbiter #(.MEM_ADDR_W(64), .MEM_DATA_W(64), .ROUND_ROBIN(1)) dut_rr (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_strb(m0_strb), .m0_wdata(m0_wdata),
    .m0_gnt(rr_m0_gnt), .m0_err(rr_m0_err), .m0_rdata(rr_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_strb(m1_strb), .m1_wdata(m1_wdata),
    .m1_gnt(rr_m1_gnt), .m1_err(rr_m1_err), .m1_rdata(rr_m1_rdata),
    .dmem_req(rr_dmem_req), .dmem_addr(rr_dmem_addr), .dmem_wen(rr_dmem_wen),
    .dmem_strb(rr_dmem_strb), .dmem_wdata(rr_dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
  );

  core_dmem_arbiter #(.MEM_ADDR_W(64), .MEM_DATA_W(64), .ROUND_ROBIN(0)) dut_fp (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_strb(m0_strb), .m0_wdata(m0_wdata),
    .m0_gnt(fp_m0_gnt), .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_strb(m1_strb), .m1_wdata(m1_wdata),
    .m1_gnt(fp_m1_gnt), .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
    .dmem_req(fp_dmem_req), .dmem_addr(fp_dmem_addr), .dmem_wen(fp_dmem_wen),
    .dmem_strb(fp_dmem_strb), .dmem_wdata(fp_dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic reset_dut();
    m0_req = 1'b0; m1_req = 1'b0; dmem_gnt = 1'b0; dmem_err = 1'b0;
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
  endtask

  initial begin
    m0_addr = 64'h100; m0_wdata = 64'hA0A0; m0_strb = 8'h0F; m0_wen = 1'b1;
    m1_addr = 64'h80;  m1_wdata = 64'hB1B1; m1_strb = 8'hF0; m1_wen = 1'b0;
    dmem_err = 1'b0; dmem_rdata = 64'h0;

    // reset forces the request and grants low regardless of inputs
    g_resetn = 1'b0; m0_req = 1'b1; m1_req = 1'b1; dmem_gnt = 1'b1;
    #1;
    chk("rst_dmem_req", {63'd0, rr_dmem_req}, 64'd0);
    chk("rst_m0_gnt", {63'd0, rr_m0_gnt}, 64'd0);
    chk("rst_m1_gnt", {63'd0, rr_m1_gnt}, 64'd0);
    tick(); tick();

    // idle bus is all-zero and a stray gnt is ignored
    g_resetn = 1'b1; m0_req = 1'b0; m1_req = 1'b0; dmem_gnt = 1'b1;
    #1;
    chk("idle_req", {63'd0, rr_dmem_req}, 64'd0);
    chk("idle_addr", rr_dmem_addr, 64'd0);
    chk("idle_strb", {56'd0, rr_dmem_strb}, 64'd0);
    chk("idle_wdata", rr_dmem_wdata, 64'd0);
    chk("idle_m0_gnt", {63'd0, rr_m0_gnt}, 64'd0);
    tick();

    // sole m1 request granted in the same cycle
    m1_req = 1'b1; dmem_gnt = 1'b1;
    #1;
    chk("m1_only_addr", rr_dmem_addr, 64'h80);
    chk("m1_only_strb", {56'd0, rr_dmem_strb}, 64'hF0);
    chk("m1_only_wen", {63'd0, rr_dmem_wen}, 64'd0);
    chk("m1_only_m1_gnt", {63'd0, rr_m1_gnt}, 64'd1);
    chk("m1_only_m0_gnt", {63'd0, rr_m0_gnt}, 64'd0);
    tick();
    // still IDLE: a fresh m0 request is served immediately
    m1_req = 1'b0; m0_req = 1'b1; dmem_gnt = 1'b1;
    #1;
    chk("post_m1_m0_gnt", {63'd0, rr_m0_gnt}, 64'd1);
    chk("post_m1_addr", rr_dmem_addr, 64'h100);
    tick();

    // both requesting, gnt on the third cycle of each transaction
    reset_dut();
    m0_req = 1'b1; m1_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 3; c++) begin
        dmem_gnt = (c == 2);
        #1;
        chk($sformatf("rr_addr_t%0d_c%0d", t, c), rr_dmem_addr, (t % 2 == 1) ? 64'h80 : 64'h100);
        chk($sformatf("rr_req_t%0d_c%0d", t, c), {63'd0, rr_dmem_req}, 64'd1);
        chk($sformatf("rr_m0gnt_t%0d_c%0d", t, c), {63'd0, rr_m0_gnt}, {63'd0, (c == 2) && (t % 2 == 0)});
        chk($sformatf("rr_m1gnt_t%0d_c%0d", t, c), {63'd0, rr_m1_gnt}, {63'd0, (c == 2) && (t % 2 == 1)});
        tick();
      end
    end

    // no preemption of BUSY0 by m1
    reset_dut();
    m0_req = 1'b1; dmem_gnt = 1'b0;
    #1;
    chk("busy0_first_addr", rr_dmem_addr, 64'h100);
    tick();
    m1_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dmem_gnt = (c == 2);
      #1;
      chk($sformatf("busy0_addr_c%0d", c), rr_dmem_addr, 64'h100);
      chk($sformatf("busy0_wdata_c%0d", c), rr_dmem_wdata, 64'hA0A0);
      chk($sformatf("busy0_m0gnt_c%0d", c), {63'd0, rr_m0_gnt}, {63'd0, c == 2});
      chk($sformatf("busy0_m1gnt_c%0d", c), {63'd0, rr_m1_gnt}, 64'd0);
      tick();
    end
    m0_req = 1'b0; dmem_gnt = 1'b1;
    #1;
    chk("after_busy0_m1_gnt", {63'd0, rr_m1_gnt}, 64'd1);
    chk("after_busy0_addr", rr_dmem_addr, 64'h80);
    tick();

    // error response on an m1 load
    m1_req = 1'b1; dmem_err = 1'b1; dmem_rdata = 64'hDEAD; dmem_gnt = 1'b1;
    #1;
    chk("err_m1_err", {63'd0, rr_m1_err}, 64'd1);
    chk("err_m1_gnt", {63'd0, rr_m1_gnt}, 64'd1);
    chk("err_m1_rdata", rr_m1_rdata, 64'hDEAD);
    chk("err_m0_rdata", rr_m0_rdata, 64'hDEAD);
    chk("err_m0_err", {63'd0, rr_m0_err}, 64'd0);
    tick();
    m1_req = 1'b0; dmem_err = 1'b0;

    // abort from BUSY1 must not update last-served (last=0 here)
    m0_req = 1'b1; dmem_gnt = 1'b1;
    #1;
    chk("pre_abort_m0_gnt", {63'd0, rr_m0_gnt}, 64'd1);
    tick();
    m0_req = 1'b0; m1_req = 1'b1; dmem_gnt = 1'b0;
    #1;
    chk("pre_abort_addr", rr_dmem_addr, 64'h80);
    tick();
    m1_req = 1'b0; m0_req = 1'b1; dmem_gnt = 1'b1;
    #1;
    chk("abort_req", {63'd0, rr_dmem_req}, 64'd0);
    chk("abort_addr", rr_dmem_addr, 64'd0);
    chk("abort_m0_gnt", {63'd0, rr_m0_gnt}, 64'd0);
    tick();
    m1_req = 1'b1; dmem_gnt = 1'b0;
    #1;
    chk("post_abort_tie_addr", rr_dmem_addr, 64'h80);
    tick();

    // reset pulsed while in BUSY1 with last=0
    g_resetn = 1'b0; m0_req = 1'b1; m1_req = 1'b1; dmem_gnt = 1'b1;
    #1;
    chk("midrst_req", {63'd0, rr_dmem_req}, 64'd0);
    chk("midrst_m0_gnt", {63'd0, rr_m0_gnt}, 64'd0);
    chk("midrst_m1_gnt", {63'd0, rr_m1_gnt}, 64'd0);
    tick();
    chk("midrst_req_2", {63'd0, rr_dmem_req}, 64'd0);
    tick();
    g_resetn = 1'b1; dmem_gnt = 1'b0;
    #1;
    chk("postrst_req", {63'd0, rr_dmem_req}, 64'd1);
    chk("postrst_addr", rr_dmem_addr, 64'h100);
    tick();

    // fixed priority: m0 wins every tie
    reset_dut();
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_gnt = 1'b1;
      #1;
      chk($sformatf("fp_m0_gnt_%0d", i), {63'd0, fp_m0_gnt}, 64'd1);
      chk($sformatf("fp_m1_gnt_%0d", i), {63'd0, fp_m1_gnt}, 64'd0);
      chk($sformatf("fp_addr_%0d", i), fp_dmem_addr, 64'h100);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; dmem_gnt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
